// File: rtl/fp_multistep_shifter.sv
// Multi-bit-per-cycle mantissa shifter: right-align by shamt, or left-normalise against the exponent.
// Define FP_SHIFT_STICKY_EN to build guard/round/sticky tracking for right shifts; otherwise grs is 0.
module fp_multistep_shifter #(
    parameter int unsigned MANT_W = 23,
    parameter int unsigned EXP_W  = 8,
    parameter int unsigned STEP   = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             mode,
    input  logic [MANT_W:0]  mant_in,
    input  logic [EXP_W-1:0] exp_in,
    input  logic [EXP_W-1:0] shamt,
    output logic [MANT_W:0]  mant_out,
    output logic [EXP_W-1:0] exp_out,
    output logic             busy,
    output logic             done,
    output logic             zero,
    output logic             underflow,
    output logic [2:0]       grs
);

    localparam int unsigned W         = MANT_W + 1;
    localparam int unsigned SHORT_AMT = MANT_W + 3;
    localparam int          TOP       = int'(W) - int'(STEP);
    localparam logic [EXP_W-1:0] STEP_E = EXP_W'(STEP);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state, state_d;
    logic [W-1:0]     mant_q, mant_d;
    logic [EXP_W-1:0] exp_q, exp_d;
    logic [EXP_W-1:0] rem_q, rem_d;
    logic             mode_q, mode_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             zero_q, zero_d;
    logic             unf_q, unf_d;
    logic [EXP_W-1:0] k_r, k_l, lz;

    // Right step size and left step size (leading zeros in the top STEP bits, limited by the exponent).
    assign k_r = (rem_q < STEP_E) ? rem_q : STEP_E;
    assign k_l = (lz < exp_q) ? lz : exp_q;

    always_comb begin
        lz = STEP_E;
        for (int i = 0; i < int'(STEP); i++) begin
            if (mant_q[TOP + i]) lz = EXP_W'(int'(STEP) - 1 - i);
        end
    end

`ifdef FP_SHIFT_STICKY_EN
    logic [2:0]   grs_q, grs_d;
    logic [W+1:0] ext;
    logic [1:0]   gr_sh;
    logic         lost;

    // Mantissa extended with guard/round; bits falling off the bottom collapse into sticky.
    always_comb begin
        ext   = {mant_q, grs_q[2:1]};
        gr_sh = 2'(ext >> k_r);
        lost  = |(ext & ~({(W + 2){1'b1}} << k_r));
    end
`endif

    always_comb begin
        state_d = state;
        mant_d  = mant_q;
        exp_d   = exp_q;
        rem_d   = rem_q;
        mode_d  = mode_q;
        busy_d  = busy_q;
        done_d  = done_q;
        zero_d  = zero_q;
        unf_d   = unf_q;
`ifdef FP_SHIFT_STICKY_EN
        grs_d   = grs_q;
`endif
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_d = SHIFT;
                    mant_d  = mant_in;
                    exp_d   = exp_in;
                    rem_d   = mode ? '0 : shamt;
                    mode_d  = mode;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    zero_d  = 1'b0;
                    unf_d   = 1'b0;
`ifdef FP_SHIFT_STICKY_EN
                    grs_d   = 3'b000;
`endif
                end
            end
            SHIFT: begin
                if (mant_q == '0) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    zero_d  = 1'b1;
                    rem_d   = '0;
                    if (mode_q) exp_d = '0;
`ifdef FP_SHIFT_STICKY_EN
                    // Remaining zero shifts still push guard/round down into sticky.
                    if (!mode_q) begin
                        if (rem_q >= EXP_W'(2))      grs_d = {2'b00, |grs_q};
                        else if (rem_q == EXP_W'(1)) grs_d = {1'b0, grs_q[2], grs_q[1] | grs_q[0]};
                    end
`endif
                end else if (!mode_q) begin
                    if (32'(rem_q) >= SHORT_AMT) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        zero_d  = 1'b1;
                        mant_d  = '0;
                        rem_d   = '0;
`ifdef FP_SHIFT_STICKY_EN
                        grs_d   = {2'b00, (|mant_q) | (|grs_q)};
`endif
                    end else begin
                        mant_d = mant_q >> k_r;
                        rem_d  = rem_q - k_r;
`ifdef FP_SHIFT_STICKY_EN
                        grs_d  = {gr_sh, grs_q[0] | lost};
`endif
                        if (rem_q == k_r) begin
                            state_d = DONE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            zero_d  = (mant_d == '0);
                        end
                    end
                end else begin
                    mant_d = mant_q << k_l;
                    exp_d  = exp_q - k_l;
                    if ((k_l < STEP_E) || mant_d[W-1] || (exp_d == '0)) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        unf_d   = (exp_d == '0) && !mant_d[W-1];
                    end
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            mant_q <= '0;
            exp_q  <= '0;
            rem_q  <= '0;
            mode_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            zero_q <= 1'b0;
            unf_q  <= 1'b0;
`ifdef FP_SHIFT_STICKY_EN
            grs_q  <= 3'b000;
`endif
        end else begin
            state  <= state_d;
            mant_q <= mant_d;
            exp_q  <= exp_d;
            rem_q  <= rem_d;
            mode_q <= mode_d;
            busy_q <= busy_d;
            done_q <= done_d;
            zero_q <= zero_d;
            unf_q  <= unf_d;
`ifdef FP_SHIFT_STICKY_EN
            grs_q  <= grs_d;
`endif
        end
    end

    assign mant_out  = mant_q;
    assign exp_out   = exp_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign zero      = zero_q;
    assign underflow = unf_q;
`ifdef FP_SHIFT_STICKY_EN
    assign grs       = grs_q;
`else
    assign grs       = 3'b000;
`endif

endmodule

// File: tb/tb_fp_multistep_shifter.sv
// Directed bench for fp_multistep_shifter at default parameters (MANT_W=23, EXP_W=8, STEP=4).
// Expected grs values follow FP_SHIFT_STICKY_EN as compiled.
module tb_fp_multistep_shifter;

`ifdef FP_SHIFT_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    typedef struct packed {
        logic        md;
        logic [23:0] mi;
        logic [7:0]  ei;
        logic [7:0]  sh;
        logic [23:0] wm;
        logic [7:0]  we;
        logic        wz;
        logic        wu;
        logic [2:0]  wg;
        logic [7:0]  lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        mode;
    logic [23:0] mant_in;
    logic [7:0]  exp_in;
    logic [7:0]  shamt;
    logic [23:0] mant_out;
    logic [7:0]  exp_out;
    logic        busy;
    logic        done;
    logic        zero;
    logic        underflow;
    logic [2:0]  grs;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fp_multistep_shifter dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .mode      (mode),
        .mant_in   (mant_in),
        .exp_in    (exp_in),
        .shamt     (shamt),
        .mant_out  (mant_out),
        .exp_out   (exp_out),
        .busy      (busy),
        .done      (done),
        .zero      (zero),
        .underflow (underflow),
        .grs       (grs)
    );

    // Issue one request and count edges from acceptance until done (bounded at 50).
    task automatic run_op(input logic m, input logic [23:0] mi, input logic [7:0] ei,
                          input logic [7:0] sh, output int cyc);
        @(negedge clk);
        start = 1'b1; mode = m; mant_in = mi; exp_in = ei; shamt = sh;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0; start = 1'b0; mode = 1'b0;
        mant_in = '0; exp_in = '0; shamt = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({mant_out, exp_out, busy, done, zero, underflow, grs} !== 39'd0) begin
            errors++;
            $display("FAIL reset_values: got mant=%h exp=%0d busy=%b done=%b z=%b u=%b grs=%b expected all zero",
                     mant_out, exp_out, busy, done, zero, underflow, grs);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_right_align;
        vec_t v[7];
        int cyc;
        v[0] = '{1'b0, 24'h800000, 8'd130, 8'd5,  24'h040000, 8'd130, 1'b0, 1'b0, 3'b000, 8'd2};
        v[1] = '{1'b0, 24'h800003, 8'd130, 8'd3,  24'h100000, 8'd130, 1'b0, 1'b0, STICKY ? 3'b011 : 3'b000, 8'd1};
        v[2] = '{1'b0, 24'hABCDEF, 8'd17,  8'd0,  24'hABCDEF, 8'd17,  1'b0, 1'b0, 3'b000, 8'd1};
        v[3] = '{1'b0, 24'hFFFFFF, 8'd64,  8'd7,  24'h01FFFF, 8'd64,  1'b0, 1'b0, STICKY ? 3'b111 : 3'b000, 8'd2};
        v[4] = '{1'b0, 24'h800000, 8'd130, 8'd24, 24'h000000, 8'd130, 1'b1, 1'b0, STICKY ? 3'b100 : 3'b000, 8'd6};
        v[5] = '{1'b0, 24'h000008, 8'd9,   8'd8,  24'h000000, 8'd9,   1'b1, 1'b0, STICKY ? 3'b001 : 3'b000, 8'd2};
        v[6] = '{1'b0, 24'h000000, 8'd9,   8'd8,  24'h000000, 8'd9,   1'b1, 1'b0, 3'b000, 8'd1};
        foreach (v[i]) begin
            run_op(v[i].md, v[i].mi, v[i].ei, v[i].sh, cyc);
            checks++;
            if ({mant_out, exp_out, zero, underflow, grs} !== {v[i].wm, v[i].we, v[i].wz, v[i].wu, v[i].wg}) begin
                errors++;
                $display("FAIL right_align[%0d]: got mant=%h exp=%0d z=%b u=%b grs=%b expected mant=%h exp=%0d z=%b u=%b grs=%b",
                         i, mant_out, exp_out, zero, underflow, grs, v[i].wm, v[i].we, v[i].wz, v[i].wu, v[i].wg);
            end
            checks++;
            if (cyc != int'(v[i].lat)) begin
                errors++;
                $display("FAIL right_align_latency[%0d]: got %0d expected %0d", i, cyc, v[i].lat);
            end
        end
    endtask

    task automatic test_right_shortcut;
        vec_t v[3];
        int cyc;
        v[0] = '{1'b0, 24'h000001, 8'd50, 8'd30, 24'h000000, 8'd50, 1'b1, 1'b0, STICKY ? 3'b001 : 3'b000, 8'd1};
        v[1] = '{1'b0, 24'hFFFFFF, 8'd50, 8'd26, 24'h000000, 8'd50, 1'b1, 1'b0, STICKY ? 3'b001 : 3'b000, 8'd1};
        v[2] = '{1'b0, 24'hFFFFFF, 8'd50, 8'd25, 24'h000000, 8'd50, 1'b1, 1'b0, STICKY ? 3'b011 : 3'b000, 8'd7};
        foreach (v[i]) begin
            run_op(v[i].md, v[i].mi, v[i].ei, v[i].sh, cyc);
            checks++;
            if ({mant_out, exp_out, zero, underflow, grs} !== {v[i].wm, v[i].we, v[i].wz, v[i].wu, v[i].wg}) begin
                errors++;
                $display("FAIL right_shortcut[%0d]: got mant=%h exp=%0d z=%b u=%b grs=%b expected mant=%h exp=%0d z=%b u=%b grs=%b",
                         i, mant_out, exp_out, zero, underflow, grs, v[i].wm, v[i].we, v[i].wz, v[i].wu, v[i].wg);
            end
            checks++;
            if (cyc != int'(v[i].lat)) begin
                errors++;
                $display("FAIL right_shortcut_latency[%0d]: got %0d expected %0d", i, cyc, v[i].lat);
            end
        end
    endtask

    task automatic test_left_normalise;
        vec_t v[7];
        int cyc;
        v[0] = '{1'b1, 24'h000001, 8'd100, 8'd200, 24'h800000, 8'd77, 1'b0, 1'b0, 3'b000, 8'd6};
        v[1] = '{1'b1, 24'hC00000, 8'd10,  8'd200, 24'hC00000, 8'd10, 1'b0, 1'b0, 3'b000, 8'd1};
        v[2] = '{1'b1, 24'h000100, 8'd5,   8'd200, 24'h002000, 8'd0,  1'b0, 1'b1, 3'b000, 8'd2};
        v[3] = '{1'b1, 24'h000000, 8'd50,  8'd200, 24'h000000, 8'd0,  1'b1, 1'b0, 3'b000, 8'd1};
        v[4] = '{1'b1, 24'h000100, 8'd100, 8'd200, 24'h800000, 8'd85, 1'b0, 1'b0, 3'b000, 8'd4};
        v[5] = '{1'b1, 24'h400000, 8'd0,   8'd200, 24'h400000, 8'd0,  1'b0, 1'b1, 3'b000, 8'd1};
        v[6] = '{1'b1, 24'h080000, 8'd4,   8'd200, 24'h800000, 8'd0,  1'b0, 1'b0, 3'b000, 8'd1};
        foreach (v[i]) begin
            run_op(v[i].md, v[i].mi, v[i].ei, v[i].sh, cyc);
            checks++;
            if ({mant_out, exp_out, zero, underflow, grs} !== {v[i].wm, v[i].we, v[i].wz, v[i].wu, v[i].wg}) begin
                errors++;
                $display("FAIL left_normalise[%0d]: got mant=%h exp=%0d z=%b u=%b grs=%b expected mant=%h exp=%0d z=%b u=%b grs=%b",
                         i, mant_out, exp_out, zero, underflow, grs, v[i].wm, v[i].we, v[i].wz, v[i].wu, v[i].wg);
            end
            checks++;
            if (cyc != int'(v[i].lat)) begin
                errors++;
                $display("FAIL left_normalise_latency[%0d]: got %0d expected %0d", i, cyc, v[i].lat);
            end
        end
    endtask

    task automatic test_back_to_back;
        int cyc;
        run_op(1'b1, 24'h000001, 8'd100, 8'd0, cyc);
        @(negedge clk);
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL b2b_done_held: got done=%b expected 1", done);
        end
        start = 1'b1; mode = 1'b0; mant_in = 24'h800003; exp_in = 8'd20; shamt = 8'd3;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if ({busy, done} !== 2'b10) begin
            errors++;
            $display("FAIL b2b_accept: got busy=%b done=%b expected busy=1 done=0", busy, done);
        end
        cyc = 0;
        while (!done && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if ({mant_out, exp_out, cyc[7:0]} !== {24'h100000, 8'd20, 8'd1}) begin
            errors++;
            $display("FAIL b2b_result: got mant=%h exp=%0d lat=%0d expected mant=100000 exp=20 lat=1",
                     mant_out, exp_out, cyc);
        end
    endtask

    task automatic test_busy_ignore;
        int cyc;
        @(negedge clk);
        start = 1'b1; mode = 1'b1; mant_in = 24'h000001; exp_in = 8'd100; shamt = 8'd0;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        repeat (2) begin
            @(posedge clk); #1;
            cyc++;
        end
        @(negedge clk);
        start = 1'b1; mode = 1'b0; mant_in = 24'hFFFFFF; exp_in = 8'd3; shamt = 8'd1;
        while (!done && cyc < 50) begin
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
        end
        checks++;
        if ({mant_out, exp_out, underflow, grs} !== {24'h800000, 8'd77, 1'b0, 3'b000}) begin
            errors++;
            $display("FAIL busy_ignore_result: got mant=%h exp=%0d u=%b grs=%b expected mant=800000 exp=77 u=0 grs=000",
                     mant_out, exp_out, underflow, grs);
        end
        checks++;
        if (cyc != 6) begin
            errors++;
            $display("FAIL busy_ignore_latency: got %0d expected 6", cyc);
        end
    endtask

    task automatic test_reset_mid;
        int cyc;
        @(negedge clk);
        start = 1'b1; mode = 1'b1; mant_in = 24'h000001; exp_in = 8'd100; shamt = 8'd0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++;
        if ({mant_out, exp_out, busy, done, zero, underflow, grs} !== 39'd0) begin
            errors++;
            $display("FAIL reset_mid_abort: got mant=%h exp=%0d busy=%b done=%b z=%b u=%b grs=%b expected all zero",
                     mant_out, exp_out, busy, done, zero, underflow, grs);
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({mant_out, exp_out, busy, done} !== 34'd0) begin
            errors++;
            $display("FAIL reset_mid_idle: got mant=%h exp=%0d busy=%b done=%b expected idle zeros",
                     mant_out, exp_out, busy, done);
        end
        run_op(1'b0, 24'h800000, 8'd130, 8'd5, cyc);
        checks++;
        if ({mant_out, cyc[7:0]} !== {24'h040000, 8'd2}) begin
            errors++;
            $display("FAIL reset_mid_restart: got mant=%h lat=%0d expected mant=040000 lat=2", mant_out, cyc);
        end
    endtask

    initial begin
        test_reset();
        test_right_align();
        test_right_shortcut();
        test_left_normalise();
        test_back_to_back();
        test_busy_ignore();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
